// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: RV32I load/store funct3 codes, LSU state encoding and byte-lane helpers.
package rv_mem_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        return f3 == F3_B ? 4'b0001 << off : f3 == F3_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend by access size.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        return f3 == F3_B  ? {{24{s[7]}}, s[7:0]} :
               f3 == F3_BU ? {24'd0, s[7:0]} :
               f3 == F3_H  ? {{16{s[15]}}, s[15:0]} :
               f3 == F3_HU ? {16'd0, s[15:0]} : s;
    endfunction
endpackage

// File: rtl/data_memory_bank.sv
// data_memory_bank: DEPTH_WORDS x 32 array with per-byte write enables and a registered read port.
module data_memory_bank #(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = 7
) (
    input  logic             clk,
    input  logic [3:0]       i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (i_we[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        if (i_re) o_rdata <= r_mem[i_idx];
    end
endmodule

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressed RV32I load/store unit over a word bank,
// one outstanding request, single-cycle response pulse with fault reporting.
module data_memory_lsu
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 128,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error
);
    localparam int IW = $clog2(DEPTH_WORDS);

    logic [1:0]  r_state, r_cnt, r_off;
    logic [2:0]  r_f3;
    logic        r_load, r_err, r_hold_error;
    logic [31:0] r_hold_rdata;
    logic [31:0] w_rdata, w_wdata;
    logic [3:0]  w_we;
    logic        w_accept, w_misaligned, w_oor, w_illegal, w_err, w_load;

    assign req_ready    = rst_n && r_state == ST_IDLE;
    assign w_accept     = req_valid && req_ready;
    assign w_misaligned = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                          (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
    assign w_oor        = 32'(req_addr[ADDR_WIDTH-1:2]) >= 32'(DEPTH_WORDS);
    assign w_illegal    = req_write ? req_funct3 > F3_W : (req_funct3 == 3'd3 || req_funct3 > F3_HU);
    assign w_err        = w_misaligned || w_oor || w_illegal;
    assign w_load       = !req_write && !w_err;
    assign w_we         = (w_accept && req_write && !w_err) ? byte_en(req_funct3, req_addr[1:0]) : 4'b0000;
    assign w_wdata      = req_funct3 == F3_B ? {4{req_wdata[7:0]}} :
                          req_funct3 == F3_H ? {2{req_wdata[15:0]}} : req_wdata;

    data_memory_bank #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IW)) u_bank (
        .clk    (clk),
        .i_we   (w_we),
        .i_re   (w_accept && w_load),
        .i_idx  (req_addr[2 +: IW]),
        .i_wdata(w_wdata),
        .o_rdata(w_rdata)
    );

    // Response is formed live in RESP and frozen into the hold registers on exit.
    assign rsp_valid = r_state == ST_RESP;
    assign rsp_rdata = rsp_valid ? (r_load ? load_ext(r_f3, r_off, w_rdata) : 32'd0) : r_hold_rdata;
    assign rsp_error = rsp_valid ? r_err : r_hold_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_off        <= 2'd0;
            r_f3         <= 3'd0;
            r_load       <= 1'b0;
            r_err        <= 1'b0;
            r_hold_rdata <= 32'd0;
            r_hold_error <= 1'b0;
        end else if (w_accept) begin
            r_off   <= req_addr[1:0];
            r_f3    <= req_funct3;
            r_load  <= w_load;
            r_err   <= w_err;
            r_cnt   <= 2'd0;
            r_state <= (w_load && READ_LATENCY > 1) ? ST_WAIT : ST_RESP;
        end else if (r_state == ST_WAIT) begin
            r_cnt   <= r_cnt + 2'd1;
            r_state <= r_cnt == 2'(READ_LATENCY - 2) ? ST_RESP : ST_WAIT;
        end else if (r_state == ST_RESP) begin
            r_state      <= ST_IDLE;
            r_hold_rdata <= rsp_rdata;
            r_hold_error <= rsp_error;
        end
    end
endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: two LSU instances (read latency 1 and 3) checked against a byte-array model.
module tb_data_memory_lsu;
    import rv_mem_pkg::*;

    localparam int DEPTH = 128;
    localparam int AW    = 10;

    typedef struct packed {
        logic          w;
        logic [2:0]    f3;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n [2], req_valid [2], req_write [2], req_ready [2], rsp_valid [2], rsp_error [2];
    logic [2:0]    req_funct3 [2];
    logic [AW-1:0] req_addr [2];
    logic [31:0]   req_wdata [2], rsp_rdata [2];
    logic [7:0]    mb [2][1024];
    int            cur, checks, fails;

    always #5 clk = ~clk;

    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
    );

    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
    );

    function automatic int rl();
        return cur == 1 ? 3 : 1;
    endfunction

    function automatic op_t op(input logic w, input logic [2:0] f3, input logic [AW-1:0] a, input logic [31:0] d);
        return {w, f3, a, d};
    endfunction

    // Reference: byte-addressed memory, size from funct3, faults from alignment/range/encoding.
    function automatic void model(input op_t o, output logic [31:0] rd, output logic er, output int lat);
        int sz;
        sz  = o.f3[1:0] == 2'd0 ? 1 : o.f3[1:0] == 2'd1 ? 2 : 4;
        er  = (o.w ? o.f3 > 3'd2 : (o.f3 == 3'd3 || o.f3 > 3'd5)) || (int'(o.a) % sz != 0) || (int'(o.a) / 4 >= DEPTH);
        rd  = 32'd0;
        lat = 1;
        if (!er && o.w)
            for (int i = 0; i < sz; i++) mb[cur][int'(o.a) + i] = o.d[8*i +: 8];
        if (!er && !o.w) begin
            lat = rl();
            for (int i = 0; i < sz; i++) rd[8*i +: 8] = mb[cur][int'(o.a) + i];
            if (!o.f3[2] && sz < 4 && rd[8*sz-1]) rd = rd | (32'hFFFF_FFFF << (8*sz));
        end
    endfunction

    task automatic xact(input op_t o, output int lat, output logic [31:0] rd, output logic er);
        int n = 0;
        @(negedge clk);
        while (!req_ready[cur] && n < 10) begin
            @(negedge clk);
            n++;
        end
        req_valid[cur] = 1'b1;
        req_write[cur] = o.w;
        req_funct3[cur] = o.f3;
        req_addr[cur] = o.a;
        req_wdata[cur] = o.d;
        @(posedge clk);
        #1 req_valid[cur] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[cur] && lat < 10);
        rd = rsp_rdata[cur];
        er = rsp_error[cur];
    endtask

    task automatic run(input op_t o, output logic [31:0] rd, output logic er, output int lat,
                       output logic [31:0] erd, output logic eer, output int elat);
        xact(o, lat, rd, er);
        model(o, erd, eer, elat);
    endtask

    task automatic test_reset;
        rst_n[cur] = 1'b1;
        #1 rst_n[cur] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready[cur] !== 1'b0 || rsp_valid[cur] !== 1'b0 || rsp_rdata[cur] !== 32'd0 || rsp_error[cur] !== 1'b0) begin
            fails++;
            $display("FAIL reset_state inst%0d: ready=%b valid=%b rdata=%h err=%b, want 0 0 00000000 0",
                     cur, req_ready[cur], rsp_valid[cur], rsp_rdata[cur], rsp_error[cur]);
        end
        rst_n[cur] = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready[cur] !== 1'b1) begin
            fails++;
            $display("FAIL reset_release inst%0d: ready=%b, want 1", cur, req_ready[cur]);
        end
    endtask

    task automatic test_init;
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, elat;
        for (int i = 0; i < DEPTH; i++) begin
            run(op(1'b1, F3_W, AW'(i * 4), $urandom), rd, er, lat, erd, eer, elat);
            checks++;
            if (rd !== erd || er !== eer || lat != elat) begin
                fails++;
                $display("FAIL init[%0d] inst%0d: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, cur, rd, er, lat, erd, eer, elat);
            end
        end
    endtask

    task automatic test_basic;
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, elat;
        op_t         ops[$];
        ops = '{op(1'b1, F3_W, 10'h004, 32'h1234_5678), op(1'b0, F3_W, 10'h004, 32'd0)};
        foreach (ops[i]) begin
            run(ops[i], rd, er, lat, erd, eer, elat);
            checks++;
            if (rd !== erd || er !== eer || lat != elat) begin
                fails++;
                $display("FAIL basic[%0d] inst%0d: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, cur, rd, er, lat, erd, eer, elat);
            end
        end
        checks++;
        if (rd !== 32'h1234_5678) begin
            fails++;
            $display("FAIL basic_lw_value inst%0d: rdata=%h, want 12345678", cur, rd);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid[cur] !== 1'b0 || rsp_rdata[cur] !== 32'h1234_5678 || req_ready[cur] !== 1'b1) begin
            fails++;
            $display("FAIL pulse_hold inst%0d: valid=%b rdata=%h ready=%b, want 0 12345678 1",
                     cur, rsp_valid[cur], rsp_rdata[cur], req_ready[cur]);
        end
    endtask

    task automatic test_sub_word;
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, elat;
        op_t         ops[$];
        ops = '{op(1'b1, F3_B, 10'h009, {24'($urandom), 8'h80}), op(1'b0, F3_B, 10'h009, 32'd0),
                op(1'b0, F3_BU, 10'h009, 32'd0), op(1'b0, F3_W, 10'h008, 32'd0),
                op(1'b1, F3_H, 10'h00E, {16'($urandom), 16'hBEEF}), op(1'b0, F3_H, 10'h00E, 32'd0),
                op(1'b0, F3_HU, 10'h00E, 32'd0), op(1'b0, F3_W, 10'h00C, 32'd0),
                op(1'b0, F3_B, 10'h00F, 32'd0), op(1'b0, F3_BU, 10'h00E, 32'd0),
                op(1'b1, F3_H, 10'h014, 32'h0000_7F01), op(1'b0, F3_H, 10'h014, 32'd0)};
        foreach (ops[i]) begin
            run(ops[i], rd, er, lat, erd, eer, elat);
            checks++;
            if (rd !== erd || er !== eer || lat != elat) begin
                fails++;
                $display("FAIL sub_word[%0d] inst%0d: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, cur, rd, er, lat, erd, eer, elat);
            end
        end
    endtask

    task automatic test_faults;
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, elat;
        op_t         ops[$];
        ops = '{op(1'b0, F3_W, 10'h002, 32'd0), op(1'b1, F3_H, 10'h011, $urandom),
                op(1'b0, F3_W, 10'h010, 32'd0), op(1'b0, F3_W, 10'h200, 32'd0),
                op(1'b0, 3'd3, 10'h000, 32'd0), op(1'b1, 3'd4, 10'h000, $urandom),
                op(1'b0, F3_HU, 10'h001, 32'd0), op(1'b0, 3'd6, 10'h008, 32'd0),
                op(1'b0, 3'd7, 10'h008, 32'd0), op(1'b1, 3'd3, 10'h008, $urandom),
                op(1'b1, F3_B, 10'h3FF, $urandom), op(1'b0, F3_W, 10'h000, 32'd0)};
        foreach (ops[i]) begin
            run(ops[i], rd, er, lat, erd, eer, elat);
            checks++;
            if (rd !== erd || er !== eer || lat != elat) begin
                fails++;
                $display("FAIL faults[%0d] inst%0d: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, cur, rd, er, lat, erd, eer, elat);
            end
        end
    endtask

    task automatic test_top_word;
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, elat;
        op_t         ops[$];
        ops = '{op(1'b1, F3_W, 10'h1FC, 32'hCAFE_F00D), op(1'b0, F3_W, 10'h1FC, 32'd0),
                op(1'b0, F3_BU, 10'h1FF, 32'd0), op(1'b0, F3_B, 10'h200, 32'd0)};
        foreach (ops[i]) begin
            run(ops[i], rd, er, lat, erd, eer, elat);
            checks++;
            if (rd !== erd || er !== eer || lat != elat) begin
                fails++;
                $display("FAIL top_word[%0d] inst%0d: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, cur, rd, er, lat, erd, eer, elat);
            end
        end
    endtask

    // req_valid stays high: one accept per READ_LATENCY+1 cycles, one response per accept.
    task automatic test_back_to_back;
        logic [31:0] erd;
        logic        eer;
        int          elat, acc = 0, rsp = 0, n = 4 * (rl() + 1);
        model(op(1'b0, F3_W, 10'h1FC, 32'd0), erd, eer, elat);
        @(negedge clk);
        req_valid[cur] = 1'b1;
        req_write[cur] = 1'b0;
        req_funct3[cur] = F3_W;
        req_addr[cur] = 10'h1FC;
        for (int i = 0; i < n; i++) begin
            if (req_ready[cur]) acc++;
            if (rsp_valid[cur]) begin
                rsp++;
                checks++;
                if (rsp_rdata[cur] !== erd || rsp_error[cur] !== 1'b0 || req_ready[cur] !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_rsp inst%0d: rdata=%h err=%b ready=%b, want %h 0 0",
                             cur, rsp_rdata[cur], rsp_error[cur], req_ready[cur], erd);
                end
            end
            @(negedge clk);
        end
        req_valid[cur] = 1'b0;
        for (int i = 0; i <= rl(); i++) begin
            if (rsp_valid[cur]) rsp++;
            @(negedge clk);
        end
        checks++;
        if (acc != n / (rl() + 1) || rsp != acc) begin
            fails++;
            $display("FAIL b2b_count inst%0d: accepts=%0d responses=%0d, want %0d each", cur, acc, rsp, n / (rl() + 1));
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, erd;
        logic        er, eer, seen = 1'b0;
        int          lat, elat;
        run(op(1'b1, F3_W, 10'h020, $urandom), rd, er, lat, erd, eer, elat);
        @(negedge clk);
        req_valid[cur] = 1'b1;
        req_write[cur] = 1'b0;
        req_funct3[cur] = F3_W;
        req_addr[cur] = 10'h020;
        @(posedge clk);
        #1 req_valid[cur] = 1'b0;
        rst_n[cur] = 1'b0;
        repeat (rl() + 2) begin
            @(negedge clk);
            if (rsp_valid[cur]) seen = 1'b1;
        end
        rst_n[cur] = 1'b1;
        #1;
        checks++;
        if (req_ready[cur] !== 1'b1 || rsp_rdata[cur] !== 32'd0 || rsp_valid[cur] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_state inst%0d: ready=%b rdata=%h valid=%b, want 1 00000000 0",
                     cur, req_ready[cur], rsp_rdata[cur], rsp_valid[cur]);
        end
        repeat (rl() + 2) begin
            @(negedge clk);
            if (rsp_valid[cur]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_drop inst%0d: rsp_valid seen=%b, want 0", cur, seen);
        end
        run(op(1'b0, F3_W, 10'h020, 32'd0), rd, er, lat, erd, eer, elat);
        checks++;
        if (rd !== erd || er !== eer || lat != elat) begin
            fails++;
            $display("FAIL reset_mid_readback inst%0d: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                     cur, rd, er, lat, erd, eer, elat);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, elat, k;
        op_t         o;
        for (int i = 0; i < 150; i++) begin
            o.w  = 1'($urandom_range(0, 1));
            o.f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, o.w ? 2 : 4);
                o.f3 = 3'(k < 3 ? k : k + 1);
            end
            o.a = AW'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) o.a = AW'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) o.a[1:0] = 2'b00;
            o.d = $urandom;
            run(o, rd, er, lat, erd, eer, elat);
            checks++;
            if (rd !== erd || er !== eer || lat != elat) begin
                fails++;
                $display("FAIL random[%0d] inst%0d w=%b f3=%0d a=%h: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, cur, o.w, o.f3, o.a, rd, er, lat, erd, eer, elat);
            end
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_funct3[i] = 3'd0;
            req_addr[i] = '0;
            req_wdata[i] = 32'd0;
        end
        for (int i = 0; i < 2; i++) begin
            cur = i;
            test_reset;
            test_init;
            test_basic;
            test_sub_word;
            test_faults;
            test_top_word;
            test_back_to_back;
            test_reset_mid;
            test_random;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
